// File: rtl/idct_pkg.sv
// rtl/idct_pkg.sv - shared widths, block size and state type for the transpose controller
package idct_pkg;

  localparam int DW       = 16;
  localparam int AW       = 6;
  localparam int BLK_SIZE = 64;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } xpose_state_e;

  // Drain read k picks row k mod 8, column k div 8 of the row-major buffer.
  function automatic logic [AW-1:0] xpose_addr(input logic [AW-1:0] k);
    return {k[2:0], k[5:3]};
  endfunction

endpackage

// File: rtl/out_skid_buf.sv
// rtl/out_skid_buf.sv - two-entry output FIFO; head stays put until popped
module out_skid_buf #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_count
);

  logic [DW-1:0] r_mem [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;
  logic          w_push;
  logic          w_pop;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/transpose_ctrl.sv
// rtl/transpose_ctrl.sv - 8x8 coefficient transpose: row-major fill, column-major drain
module transpose_ctrl #(
  parameter int DW = 16,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data_in,
  output logic          mem_write_read,
  input  logic [DW-1:0] mem_data_out,
  output logic          block_done
);

  import idct_pkg::*;

  localparam int             CW       = $clog2(BLK_SIZE);
  localparam logic [CW:0]    CNT_LAST = (CW+1)'(BLK_SIZE - 1);
  localparam logic [CW:0]    CNT_FULL = (CW+1)'(BLK_SIZE);
  localparam logic [CW:0]    CNT_ONE  = (CW+1)'(1);
  localparam logic [AW-1:0]  WR_LAST  = AW'(BLK_SIZE - 1);

  xpose_state_e  r_state;
  xpose_state_e  w_state_nxt;
  logic [AW-1:0] r_wr_cnt;
  logic [AW-1:0] r_last_addr;
  logic [CW:0]   r_rd_cnt;
  logic [CW:0]   r_out_cnt;
  logic          r_in_flight;

  logic          w_in_xfer;
  logic          w_pop;
  logic          w_issue;
  logic          w_last_out;
  logic [2:0]    w_occ;
  logic [AW-1:0] w_rd_addr;
  logic          w_fifo_valid;
  logic [DW-1:0] w_fifo_data;
  logic [1:0]    w_fifo_cnt;

  assign w_in_xfer  = in_valid && (r_state == FILL) && !rst_b;
  assign w_pop      = w_fifo_valid && out_ready && !rst_b;
  assign w_last_out = w_pop && (r_out_cnt == CNT_LAST);
  assign w_rd_addr  = xpose_addr(r_rd_cnt[CW-1:0]);

  // Buffered plus in-flight words after this cycle's pop must leave room for one more.
  assign w_occ   = {1'b0, w_fifo_cnt} + {2'b00, r_in_flight} - {2'b00, w_pop};
  assign w_issue = (r_state == DRAIN) && !rst_b && (r_rd_cnt < CNT_FULL) && (w_occ < 3'd2);

  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_state     <= FILL;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_out_cnt   <= '0;
      r_in_flight <= 1'b0;
      r_last_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_flight <= w_issue;
      if (w_in_xfer) begin
        r_wr_cnt <= r_wr_cnt + AW'(1);
      end
      if (w_issue) begin
        r_rd_cnt    <= r_rd_cnt + CNT_ONE;
        r_last_addr <= w_rd_addr;
      end
      if (w_pop) begin
        r_out_cnt <= r_out_cnt + CNT_ONE;
      end
      if (w_last_out) begin
        r_rd_cnt  <= '0;
        r_out_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    in_ready       = 1'b0;
    mem_write_read = 1'b0;
    mem_addr       = '0;
    unique case (r_state)
      FILL: begin
        in_ready = !rst_b;
        mem_addr = rst_b ? '0 : r_wr_cnt;
        if (w_in_xfer && (r_wr_cnt == WR_LAST)) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        mem_write_read = !rst_b;
        if (!rst_b) begin
          mem_addr = w_issue ? w_rd_addr : r_last_addr;
        end
        if (w_last_out) begin
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  // Memory read data lands exactly one cycle after issue, tracked by r_in_flight.
  out_skid_buf #(
    .DW (DW)
  ) u_out_skid_buf (
    .clk     (clk),
    .rst_b   (rst_b),
    .i_push  (r_in_flight),
    .i_data  (mem_data_out),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_cnt)
  );

  assign mem_data_in = in_data;
  assign out_valid   = w_fifo_valid && !rst_b;
  assign out_data    = rst_b ? '0 : w_fifo_data;
  assign block_done  = w_last_out;

endmodule
